// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage -- ID/EX pipeline register with operand forwarding and
//                load-use hazard detection for a 5-stage in-order pipeline.
//
// Configuration macro: ID_EX_FWD_EN
//   defined   : EX/MEM and MEM/WB results are forwarded onto operands A/B and
//               store data; load_use_stall only covers a load in EX.
//   undefined : operands come straight from the registered register-file
//               reads; load_use_stall also covers any pending write in EX or
//               EX/MEM to a source register.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   i_stall, i_flush            hold / kill the stage contents
//   i_id_*                      decoded instruction from the ID stage
//   i_exmem_*, i_memwb_*        forwarding sources (write enable, rd, value)
//   o_ex_a, o_ex_b              ALU operands after forwarding / imm select
//   o_ex_store_data             forwarded rt value for stores
//   o_ex_aluop/shamt/rd         registered instruction fields
//   o_ex_valid/regwrite/...     registered controls
//   o_load_use_stall            freeze PC and IF/ID for one cycle
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_stall,
    input  logic         i_flush,
    input  logic         i_id_valid,
    input  logic [W-1:0] i_id_rs_data,
    input  logic [W-1:0] i_id_rt_data,
    input  logic [W-1:0] i_id_imm,
    input  logic [4:0]   i_id_rs,
    input  logic [4:0]   i_id_rt,
    input  logic [4:0]   i_id_rd,
    input  logic [3:0]   i_id_aluop,
    input  logic [4:0]   i_id_shamt,
    input  logic         i_id_alusrc,
    input  logic         i_id_regwrite,
    input  logic         i_id_memread,
    input  logic         i_id_memwrite,
    input  logic         i_id_memtoreg,
    input  logic         i_exmem_regwrite,
    input  logic         i_memwb_regwrite,
    input  logic [4:0]   i_exmem_rd,
    input  logic [4:0]   i_memwb_rd,
    input  logic [W-1:0] i_exmem_result,
    input  logic [W-1:0] i_memwb_result,
    output logic [W-1:0] o_ex_a,
    output logic [W-1:0] o_ex_b,
    output logic [3:0]   o_ex_aluop,
    output logic [4:0]   o_ex_shamt,
    output logic [4:0]   o_ex_rd,
    output logic [W-1:0] o_ex_store_data,
    output logic         o_ex_valid,
    output logic         o_ex_regwrite,
    output logic         o_ex_memread,
    output logic         o_ex_memwrite,
    output logic         o_ex_memtoreg,
    output logic         o_load_use_stall
);

    // Stage registers
    logic         r_valid, r_regwrite, r_memread, r_memwrite, r_memtoreg;
    logic         r_alusrc;
    logic [3:0]   r_aluop;
    logic [4:0]   r_shamt, r_rd, r_rs, r_rt;
    logic [W-1:0] r_rs_data, r_rt_data, r_imm;

    // Next-state values
    logic         w_valid, w_regwrite, w_memread, w_memwrite, w_memtoreg;
    logic         w_alusrc;
    logic [3:0]   w_aluop;
    logic [4:0]   w_shamt, w_rd, w_rs, w_rt;
    logic [W-1:0] w_rs_data, w_rt_data, w_imm;

    logic         w_load;
    logic         w_bubble;
    logic         w_load_use;
    logic [W-1:0] w_fa, w_fb;

`ifdef ID_EX_FWD_EN
    // EX/MEM beats MEM/WB; register 0 is hard-wired and never forwarded.
    function automatic logic [W-1:0] fwd_sel(
        input logic [4:0]   src,
        input logic [W-1:0] reg_val,
        input logic         em_we,
        input logic [4:0]   em_rd,
        input logic [W-1:0] em_val,
        input logic         mw_we,
        input logic [4:0]   mw_rd,
        input logic [W-1:0] mw_val
    );
        if (src == 5'd0) begin
            return reg_val;
        end else if (em_we && (em_rd == src)) begin
            return em_val;
        end else if (mw_we && (mw_rd == src)) begin
            return mw_val;
        end else begin
            return reg_val;
        end
    endfunction
`else
    // True when a nonzero source register has a write still in flight.
    function automatic logic raw_hit(
        input logic [4:0] src,
        input logic       ex_v,
        input logic       ex_we,
        input logic [4:0] ex_rd,
        input logic       em_we,
        input logic [4:0] em_rd
    );
        return (src != 5'd0) &&
               ((ex_v && ex_we && (ex_rd == src)) || (em_we && (em_rd == src)));
    endfunction
`endif

    // Hazard detection against the instruction currently in EX
    always_comb begin
        w_load_use = i_id_valid && r_valid && r_memread && (r_rd != 5'd0) &&
                     ((r_rd == i_id_rs) || (r_rd == i_id_rt));
`ifndef ID_EX_FWD_EN
        w_load_use = w_load_use || (i_id_valid &&
            (raw_hit(i_id_rs, r_valid, r_regwrite, r_rd, i_exmem_regwrite, i_exmem_rd) ||
             raw_hit(i_id_rt, r_valid, r_regwrite, r_rd, i_exmem_regwrite, i_exmem_rd)));
`endif
    end

    // Next-state selection: bubble on flush or load-use, otherwise capture
    always_comb begin
        // flush overrides stall; a load-use bubble only loads when not stalled
        w_load   = i_flush || !i_stall;
        w_bubble = i_flush || w_load_use;
        if (w_bubble) begin
            w_valid    = 1'b0;
            w_regwrite = 1'b0;
            w_memread  = 1'b0;
            w_memwrite = 1'b0;
            w_memtoreg = 1'b0;
            w_alusrc   = 1'b0;
            w_aluop    = 4'd0;
            w_shamt    = 5'd0;
            w_rd       = 5'd0;
            w_rs       = 5'd0;
            w_rt       = 5'd0;
            w_rs_data  = '0;
            w_rt_data  = '0;
            w_imm      = '0;
        end else begin
            // controls of a non-instruction are forced off
            w_valid    = i_id_valid;
            w_regwrite = i_id_valid && i_id_regwrite;
            w_memread  = i_id_valid && i_id_memread;
            w_memwrite = i_id_valid && i_id_memwrite;
            w_memtoreg = i_id_valid && i_id_memtoreg;
            w_alusrc   = i_id_alusrc;
            w_aluop    = i_id_aluop;
            w_shamt    = i_id_shamt;
            w_rd       = i_id_rd;
            w_rs       = i_id_rs;
            w_rt       = i_id_rt;
            w_rs_data  = i_id_rs_data;
            w_rt_data  = i_id_rt_data;
            w_imm      = i_id_imm;
        end
    end

    // Stage register update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alusrc   <= 1'b0;
            r_aluop    <= 4'd0;
            r_shamt    <= 5'd0;
            r_rd       <= 5'd0;
            r_rs       <= 5'd0;
            r_rt       <= 5'd0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
        end else if (w_load) begin
            r_valid    <= w_valid;
            r_regwrite <= w_regwrite;
            r_memread  <= w_memread;
            r_memwrite <= w_memwrite;
            r_memtoreg <= w_memtoreg;
            r_alusrc   <= w_alusrc;
            r_aluop    <= w_aluop;
            r_shamt    <= w_shamt;
            r_rd       <= w_rd;
            r_rs       <= w_rs;
            r_rt       <= w_rt;
            r_rs_data  <= w_rs_data;
            r_rt_data  <= w_rt_data;
            r_imm      <= w_imm;
        end
    end

    // Operand forwarding; evaluated on held fields too, since sources move
    always_comb begin
`ifdef ID_EX_FWD_EN
        w_fa = fwd_sel(r_rs, r_rs_data, i_exmem_regwrite, i_exmem_rd, i_exmem_result,
                       i_memwb_regwrite, i_memwb_rd, i_memwb_result);
        w_fb = fwd_sel(r_rt, r_rt_data, i_exmem_regwrite, i_exmem_rd, i_exmem_result,
                       i_memwb_regwrite, i_memwb_rd, i_memwb_result);
`else
        w_fa = r_rs_data;
        w_fb = r_rt_data;
`endif
    end

    assign o_ex_a           = w_fa;
    assign o_ex_b           = r_alusrc ? r_imm : w_fb;
    assign o_ex_store_data  = w_fb;
    assign o_ex_aluop       = r_aluop;
    assign o_ex_shamt       = r_shamt;
    assign o_ex_rd          = r_rd;
    assign o_ex_valid       = r_valid;
    assign o_ex_regwrite    = r_regwrite;
    assign o_ex_memread     = r_memread;
    assign o_ex_memwrite    = r_memwrite;
    assign o_ex_memtoreg    = r_memtoreg;
    assign o_load_use_stall = w_load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expectations tagged with
// the cycle they apply to; a negedge monitor pops and compares them.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam int S_A = 0, S_B = 1, S_ST = 2, S_OP = 3, S_SH = 4, S_RD = 5;
    localparam int S_V = 6, S_RW = 7, S_MR = 8, S_MW = 9, S_MTR = 10, S_LUS = 11;

    logic        clk, rst, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [3:0]  id_aluop;
    logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_aluop;
    logic [4:0]  ex_shamt, ex_rd;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic        load_use_stall;

    id_ex_stage #(.W(32)) dut (
        .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush),
        .i_id_valid(id_valid), .i_id_rs_data(id_rs_data), .i_id_rt_data(id_rt_data),
        .i_id_imm(id_imm), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rd(id_rd),
        .i_id_aluop(id_aluop), .i_id_shamt(id_shamt), .i_id_alusrc(id_alusrc),
        .i_id_regwrite(id_regwrite), .i_id_memread(id_memread),
        .i_id_memwrite(id_memwrite), .i_id_memtoreg(id_memtoreg),
        .i_exmem_regwrite(exmem_regwrite), .i_memwb_regwrite(memwb_regwrite),
        .i_exmem_rd(exmem_rd), .i_memwb_rd(memwb_rd),
        .i_exmem_result(exmem_result), .i_memwb_result(memwb_result),
        .o_ex_a(ex_a), .o_ex_b(ex_b), .o_ex_aluop(ex_aluop), .o_ex_shamt(ex_shamt),
        .o_ex_rd(ex_rd), .o_ex_store_data(ex_store_data), .o_ex_valid(ex_valid),
        .o_ex_regwrite(ex_regwrite), .o_ex_memread(ex_memread),
        .o_ex_memwrite(ex_memwrite), .o_ex_memtoreg(ex_memtoreg),
        .o_load_use_stall(load_use_stall)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] mon_got;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] outval(input int sel);
        case (sel)
            S_A:   return ex_a;
            S_B:   return ex_b;
            S_ST:  return ex_store_data;
            S_OP:  return {28'd0, ex_aluop};
            S_SH:  return {27'd0, ex_shamt};
            S_RD:  return {27'd0, ex_rd};
            S_V:   return {31'd0, ex_valid};
            S_RW:  return {31'd0, ex_regwrite};
            S_MR:  return {31'd0, ex_memread};
            S_MW:  return {31'd0, ex_memwrite};
            S_MTR: return {31'd0, ex_memtoreg};
            S_LUS: return {31'd0, load_use_stall};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: compare every expectation that falls due in this cycle
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                mon_got  = outval(sb[i].sel);
                n_checks = n_checks + 1;
                if (sb[i].due < cyc || mon_got !== sb[i].val)
                    $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h",
                             sb[i].name, cyc, mon_got, sb[i].val);
                else
                    n_pass = n_pass + 1;
                sb.delete(i);
            end
        end
    end

    // off=0: current-cycle output, off=1: after the next clock edge
    task automatic chk(input string name, input int sel, input logic [31:0] val,
                       input int off);
        exp_t e;
        e.name = name; e.sel = sel; e.val = val; e.due = cyc + off;
        sb.push_back(e);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                          input logic [4:0] rt, input logic [31:0] rtd,
                          input logic [4:0] rd, input logic [3:0] op,
                          input logic [4:0] sh, input logic src,
                          input logic [31:0] imm, input logic rw, input logic mr,
                          input logic mw, input logic mtr);
        id_valid = v; id_rs = rs; id_rs_data = rsd; id_rt = rt; id_rt_data = rtd;
        id_rd = rd; id_aluop = op; id_shamt = sh; id_alusrc = src; id_imm = imm;
        id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_memtoreg = mtr;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] ev,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] mv);
        exmem_regwrite = ew; exmem_rd = erd; exmem_result = ev;
        memwb_regwrite = mw; memwb_rd = mrd; memwb_result = mv;
    endtask

    task automatic idle_id();
        set_id(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 4'd0, 5'd0, 1'b0, 32'd0,
               1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        idle_id();
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step(); step();
        // reset state
        chk("rst_a", S_A, 32'd0, 0);    chk("rst_b", S_B, 32'd0, 0);
        chk("rst_st", S_ST, 32'd0, 0);  chk("rst_v", S_V, 32'd0, 0);
        chk("rst_rw", S_RW, 32'd0, 0);  chk("rst_op", S_OP, 32'd0, 0);
        chk("rst_rd", S_RD, 32'd0, 0);  chk("rst_lus", S_LUS, 32'd0, 0);
        n_checks = n_checks + 1;
        if (ex_valid !== 1'b0) $display("FAIL rst_now_v got=%0b", ex_valid);
        else n_pass = n_pass + 1;
        n_checks = n_checks + 1;
        if (ex_a !== 32'd0) $display("FAIL rst_now_a got=0x%0h", ex_a);
        else n_pass = n_pass + 1;
        n_checks = n_checks + 1;
        if (ex_regwrite !== 1'b0) $display("FAIL rst_now_rw got=%0b", ex_regwrite);
        else n_pass = n_pass + 1;
        n_checks = n_checks + 1;
        if (load_use_stall !== 1'b0) $display("FAIL rst_now_lus got=%0b", load_use_stall);
        else n_pass = n_pass + 1;

        // release reset mid-stall: stays a bubble
        step();
        rst = 1'b0; stall = 1'b1;
        set_id(1'b1, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 4'd0, 5'd4, 1'b0, 32'd0,
               1'b1, 1'b0, 1'b0, 1'b0);
        chk("rel_stall_v", S_V, 32'd0, 1);

        // add r3 = r1(5) + r2(7)
        step();
        stall = 1'b0;
        chk("add_lus", S_LUS, 32'd0, 0);
        chk("add_a", S_A, 32'd5, 1);    chk("add_b", S_B, 32'd7, 1);
        chk("add_st", S_ST, 32'd7, 1);  chk("add_op", S_OP, 32'd0, 1);
        chk("add_rd", S_RD, 32'd3, 1);  chk("add_v", S_V, 32'd1, 1);
        chk("add_rw", S_RW, 32'd1, 1);  chk("add_sh", S_SH, 32'd4, 1);

        // sub using r3, EX/MEM holds r3=12
        step();
        set_id(1'b1, 5'd3, 32'd99, 5'd0, 32'd0, 5'd6, 4'd1, 5'd0, 1'b0, 32'd0,
               1'b1, 1'b0, 1'b0, 1'b0);
        set_fwd(1'b1, 5'd3, 32'd12, 1'b0, 5'd0, 32'd0);
        chk("sub_lus", S_LUS, FWD ? 32'd0 : 32'd1, 0);
        chk("sub_v", S_V, FWD ? 32'd1 : 32'd0, 1);
        chk("sub_rw", S_RW, FWD ? 32'd1 : 32'd0, 1);
        chk("sub_a", S_A, FWD ? 32'd12 : 32'd0, 1);
        chk("sub_op", S_OP, FWD ? 32'd1 : 32'd0, 1);

        // hold; then forwarding source moves to MEM/WB during the hold
        step();
        stall = 1'b1; idle_id();
        step();
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h20);
        chk("hold_v", S_V, FWD ? 32'd1 : 32'd0, 0);
        chk("hold_fwd_a", S_A, FWD ? 32'h20 : 32'd0, 0);

        // rs=4 with immediate operand
        step();
        stall = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        set_id(1'b1, 5'd4, 32'h44, 5'd0, 32'd0, 5'd7, 4'd2, 5'd0, 1'b1, 32'h100,
               1'b1, 1'b0, 1'b0, 1'b0);
        chk("imm_lus", S_LUS, 32'd0, 0);
        chk("imm_b", S_B, 32'h100, 1);  chk("imm_op", S_OP, 32'd2, 1);
        chk("imm_v", S_V, 32'd1, 1);

        // both stages match r4: EX/MEM wins (raw value without forwarding)
        step();
        stall = 1'b1; idle_id();
        set_fwd(1'b1, 5'd4, 32'h10, 1'b1, 5'd4, 32'h20);
        chk("prio_a", S_A, FWD ? 32'h10 : 32'h44, 0);

        // r0 is never forwarded
        step();
        stall = 1'b0;
        set_fwd(1'b1, 5'd0, 32'hdead, 1'b1, 5'd0, 32'hbeef);
        set_id(1'b1, 5'd0, 32'h55, 5'd0, 32'h66, 5'd8, 4'd3, 5'd0, 1'b0, 32'd0,
               1'b1, 1'b0, 1'b0, 1'b0);
        chk("r0_lus", S_LUS, 32'd0, 0);
        chk("r0_a", S_A, 32'h55, 1);    chk("r0_b", S_B, 32'h66, 1);
        step();
        stall = 1'b1; idle_id();

        // lw r5 then dependent add -> load-use bubble
        step();
        stall = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        set_id(1'b1, 5'd1, 32'h1000, 5'd5, 32'd0, 5'd5, 4'd0, 5'd0, 1'b1, 32'd4,
               1'b1, 1'b1, 1'b0, 1'b1);
        chk("lw_mr", S_MR, 32'd1, 1);   chk("lw_mtr", S_MTR, 32'd1, 1);
        chk("lw_rd", S_RD, 32'd5, 1);   chk("lw_v", S_V, 32'd1, 1);
        step();
        set_id(1'b1, 5'd5, 32'd0, 5'd2, 32'd0, 5'd9, 4'd0, 5'd0, 1'b0, 32'd0,
               1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_lus", S_LUS, 32'd1, 0);
        chk("lu_v", S_V, 32'd0, 1);     chk("lu_rw", S_RW, 32'd0, 1);
        chk("lu_mr", S_MR, 32'd0, 1);

        // capture, then 3 stalled cycles with changing inputs
        step();
        set_id(1'b1, 5'd10, 32'hA, 5'd11, 32'hB, 5'd12, 4'd4, 5'd7, 1'b0, 32'd0,
               1'b1, 1'b0, 1'b1, 1'b0);
        chk("st0_lus", S_LUS, 32'd0, 0);
        chk("st0_op", S_OP, 32'd4, 1);  chk("st0_mw", S_MW, 32'd1, 1);
        chk("st0_a", S_A, 32'hA, 1);    chk("st0_b", S_B, 32'hB, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            stall = 1'b1;
            set_id(1'b1, 5'(13 + k), 32'(100 + k), 5'(16 + k), 32'(200 + k),
                   5'(20 + k), 4'(5 + k), 5'(k), 1'b1, 32'(300 + k),
                   1'b0, 1'b1, 1'b0, 1'b1);
            chk("stall_op", S_OP, 32'd4, 1);  chk("stall_rd", S_RD, 32'd12, 1);
            chk("stall_a", S_A, 32'hA, 1);    chk("stall_sh", S_SH, 32'd7, 1);
        end

        // flush beats stall
        step();
        flush = 1'b1;
        chk("fl_v", S_V, 32'd0, 1);     chk("fl_rw", S_RW, 32'd0, 1);
        chk("fl_mw", S_MW, 32'd0, 1);   chk("fl_a", S_A, 32'd0, 1);
        chk("fl_op", S_OP, 32'd0, 1);

        // id_valid=0 squashes controls, data still captured
        step();
        flush = 1'b0; stall = 1'b0;
        set_id(1'b0, 5'd2, 32'h77, 5'd0, 32'd0, 5'd1, 4'd6, 5'd0, 1'b0, 32'd0,
               1'b1, 1'b1, 1'b1, 1'b1);
        chk("nv_rw", S_RW, 32'd0, 1);   chk("nv_mr", S_MR, 32'd0, 1);
        chk("nv_mw", S_MW, 32'd0, 1);   chk("nv_mtr", S_MTR, 32'd0, 1);
        chk("nv_op", S_OP, 32'd6, 1);   chk("nv_a", S_A, 32'h77, 1);

        // reset in the middle of operation
        step();
        set_id(1'b1, 5'd1, 32'h123, 5'd2, 32'h456, 5'd1, 4'd7, 5'd3, 1'b0, 32'd0,
               1'b1, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        chk("mr_v", S_V, 32'd0, 0);     chk("mr_a", S_A, 32'd0, 0);
        chk("mr_b", S_B, 32'd0, 0);     chk("mr_rd", S_RD, 32'd0, 0);
        chk("mr_op", S_OP, 32'd0, 0);
        #1;
        n_checks = n_checks + 1;
        if (ex_valid !== 1'b0) $display("FAIL mr_now_v got=%0b", ex_valid);
        else n_pass = n_pass + 1;
        n_checks = n_checks + 1;
        if (ex_b !== 32'd0) $display("FAIL mr_now_b got=0x%0h", ex_b);
        else n_pass = n_pass + 1;
        step();
        rst = 1'b0; stall = 1'b1;
        chk("mr_hold_v", S_V, 32'd0, 1);
        step();
        stall = 1'b0;
        set_id(1'b1, 5'd1, 32'h9, 5'd2, 32'h8, 5'd2, 4'd8, 5'd0, 1'b0, 32'd0,
               1'b1, 1'b0, 1'b0, 1'b0);
        chk("mr_cap_v", S_V, 32'd1, 1); chk("mr_cap_rd", S_RD, 32'd2, 1);
        chk("mr_cap_op", S_OP, 32'd8, 1);
        step();
        idle_id();

        // bounded drain of the scoreboard
        for (int k = 0; k < 5 && sb.size() > 0; k++) step();
        while (sb.size() > 0) begin
            n_checks = n_checks + 1;
            $display("FAIL %s never compared (due cyc %0d)", sb[0].name, sb[0].due);
            void'(sb.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
